// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a one-deep holding register.
// Frame is start, DATA_BITS data (LSB first), optional parity, then 1 or 2 stop bits.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    // state    | meaning
    // S_IDLE   | line high, waiting for the holding register to fill
    // S_START  | start bit (line low)
    // S_DATA   | data bit idx_q on the line
    // S_PARITY | parity over the captured data bits
    // S_STOP   | stop bit(s), line high; stop_q counts which one

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = 1'(PARITY_ODD);

    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_chk_pen
        $error("uart_tx_cfg: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_podd
        $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 accept, bit_end, load;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        serial_d = 1'b1;
        active_d = 1'b1;
        load     = 1'b0;

        accept  = i_Tx_DV && ready_q;
        bit_end = (cnt_q == CNT_LAST);

        if (accept) begin
            hold_d  = i_Tx_Byte;
            ready_d = 1'b0;
        end

        if (state_q == S_IDLE || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                load = !ready_q;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        done_d = 1'b1;
                        // A byte landing on this same edge bypasses the holding register.
                        if (!ready_q || accept) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d = S_START;
            shift_d = ready_q ? i_Tx_Byte : hold_q;
            ready_d = 1'b1;
        end

        unique case (state_d)
            S_IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
            end
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[idx_d];
            S_PARITY: serial_d = (^shift_d) ^ PAR_ODD;
            default:  serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            hold_q   <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            serial_q <= serial_d;
            active_q <= active_d;
        end
    end

    assign o_Tx_Ready  = ready_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed vectors over four frame formats (8N1, 8E1, 8O1, 7N2) at 4 clocks/bit,
// plus back-to-back, same-edge reload, ignored-DV and mid-frame reset sequences on the 8N1 instance.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst_n;
    logic       dv [4];
    logic [7:0] tx_byte;
    logic       ready_w  [4];
    logic       active_w [4];
    logic       serial_w [4];
    logic       done_w   [4];

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(ready_w[0]), .o_Tx_Active(active_w[0]), .o_Tx_Serial(serial_w[0]), .o_Tx_Done(done_w[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(ready_w[1]), .o_Tx_Active(active_w[1]), .o_Tx_Serial(serial_w[1]), .o_Tx_Done(done_w[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(ready_w[2]), .o_Tx_Active(active_w[2]), .o_Tx_Serial(serial_w[2]), .o_Tx_Done(done_w[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(tx_byte[6:0]),
        .o_Tx_Ready(ready_w[3]), .o_Tx_Active(active_w[3]), .o_Tx_Serial(serial_w[3]), .o_Tx_Done(done_w[3]));

    // line: serial level of each bit period in transmit order (index 0 = start bit)
    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        logic [0:11] line;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] s_seen;
        logic [3:0] a_seen;
        logic       d_any;
        d_any = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d ready_before", id), ready_w[v.sel], 1);
        dv[v.sel] = 1'b1;
        tx_byte   = v.data;
        @(negedge clk);
        dv[v.sel] = 1'b0;
        check($sformatf("v%0d accept_serial", id), serial_w[v.sel], 1);
        check($sformatf("v%0d accept_active", id), active_w[v.sel], 0);
        check($sformatf("v%0d accept_ready", id), ready_w[v.sel], 0);
        for (int b = 0; b < v.nbits; b++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                s_seen[k] = serial_w[v.sel];
                a_seen[k] = active_w[v.sel];
                d_any     = d_any | done_w[v.sel];
            end
            check($sformatf("v%0d bit%0d serial", id, b), s_seen, {4{v.line[b]}});
            check($sformatf("v%0d bit%0d active", id, b), a_seen, 4'hF);
        end
        check($sformatf("v%0d done_in_frame", id), d_any, 0);
        @(negedge clk);
        check($sformatf("v%0d done_pulse", id), done_w[v.sel], 1);
        check($sformatf("v%0d active_end", id), active_w[v.sel], 0);
        check($sformatf("v%0d serial_end", id), serial_w[v.sel], 1);
        check($sformatf("v%0d ready_end", id), ready_w[v.sel], 1);
        @(negedge clk);
        check($sformatf("v%0d done_once", id), done_w[v.sel], 0);
    endtask

    // Cycle-by-cycle watch of the 8N1 instance; cycle c is the period after the c-th edge past acceptance.
    task automatic watch(input string tag, input int ncyc, input logic [0:19] line, input int nbits,
                         input int d1, input int d2);
        logic es, ea, ed;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            es = (c <= 4 * nbits) ? line[(c - 1) / 4] : 1'b1;
            ea = (c <= 4 * nbits);
            ed = (c == d1) || (c == d2);
            check($sformatf("%s c%0d serial", tag, c), serial_w[0], es);
            check($sformatf("%s c%0d active", tag, c), active_w[0], ea);
            check($sformatf("%s c%0d done", tag, c), done_w[0], ed);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s u%0d ready", tag, i), ready_w[i], 1);
            check($sformatf("%s u%0d active", tag, i), active_w[i], 0);
            check($sformatf("%s u%0d serial", tag, i), serial_w[i], 1);
            check($sformatf("%s u%0d done", tag, i), done_w[i], 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{0, 8'hA5, 10, 12'b0101_0010_1111};
        vecs[1] = '{0, 8'h00, 10, 12'b0000_0000_0111};
        vecs[2] = '{0, 8'hFF, 10, 12'b0111_1111_1111};
        vecs[3] = '{1, 8'h07, 11, 12'b0111_0000_0111};
        vecs[4] = '{2, 8'h07, 11, 12'b0111_0000_0011};
        vecs[5] = '{1, 8'h03, 11, 12'b0110_0000_0011};
        vecs[6] = '{2, 8'h03, 11, 12'b0110_0000_0111};
        vecs[7] = '{3, 8'h55, 10, 12'b0101_0101_1111};
        vecs[8] = '{3, 8'h0F, 10, 12'b0111_1000_1111};
        vecs[9] = '{0, 8'h3C, 10, 12'b0001_1110_0111};

        rst_n   = 1'b0;
        tx_byte = 8'h00;
        for (int i = 0; i < 4; i++) dv[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Back-to-back 0x12 then 0x34; 0x56 offered while holding full must be dropped.
        @(negedge clk);
        dv[0] = 1'b1;
        tx_byte = 8'h12;
        @(negedge clk);
        dv[0] = 1'b0;
        fork
            watch("b2b", 130, 20'b0010010001_0001011001, 20, 41, 81);
            begin
                repeat (3) @(negedge clk);
                check("b2b ready_c3", ready_w[0], 1);
                dv[0]   = 1'b1;
                tx_byte = 8'h34;
                @(negedge clk);
                check("b2b ready_c4", ready_w[0], 0);
                tx_byte = 8'h56;
                repeat (10) @(negedge clk);
                dv[0] = 1'b0;
                repeat (26) @(negedge clk);
                check("b2b ready_c40", ready_w[0], 0);
                @(negedge clk);
                check("b2b ready_c41", ready_w[0], 1);
            end
        join

        // Byte accepted on the very edge the stop bit ends.
        @(negedge clk);
        dv[0] = 1'b1;
        tx_byte = 8'h81;
        @(negedge clk);
        dv[0] = 1'b0;
        fork
            watch("same_edge", 90, 20'b0100000011_0111100001, 20, 41, 81);
            begin
                repeat (40) @(negedge clk);
                check("same_edge ready_c40", ready_w[0], 1);
                dv[0]   = 1'b1;
                tx_byte = 8'h0F;
                @(negedge clk);
                dv[0] = 1'b0;
                check("same_edge ready_c41", ready_w[0], 1);
            end
        join

        // Reset in the middle of data bit 3 of 0xF0 (line low there).
        @(negedge clk);
        dv[0] = 1'b1;
        tx_byte = 8'hF0;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("rst pre_serial", serial_w[0], 0);
        check("rst pre_active", active_w[0], 1);
        rst_n = 1'b0;
        #1;
        check("rst serial", serial_w[0], 1);
        check("rst active", active_w[0], 0);
        check("rst ready", ready_w[0], 1);
        check("rst done", done_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst idle_serial", serial_w[0], 1);
        check("rst idle_done", done_w[0], 0);
        run_vec(vecs[9], 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
